load_store_unit: RTL

Initiator side of the CPU data-memory port: accepts one load/store request at a time from the MEM pipeline stage and drives the word-addressed data memory (mem_read/mem_write/mem_addr/mem_wdata, readData back). Handles byte/halfword/word sizes, sign/zero extension, alignment and range checks, and read-modify-write for sub-word stores, since the memory only writes whole words. Returns exactly one response per accepted request.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/lsu_lane_merge.sv | 54 +++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - bit positions inside the 4-bit request op field
//   - access-size encodings and FSM state encoding
//   - lsu_req_err(): decides whether a request is rejected without
//     touching memory (illegal size, misalignment, address out of range)
package lsu_pkg;

    localparam int OP_STORE_BIT    = 3;
    localparam int OP_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // addr_w is the word-address width; byte addresses at or above
    // 4 << addr_w have a bit set above addr_w+1 and are out of range.
    function automatic logic lsu_req_err(input logic [3:0]  op,
                                         input logic [31:0] addr,
                                         input int          addr_w);
        logic        err;
        logic [31:0] hi;
        hi  = addr >> (addr_w + 2);
        err = (hi != 32'd0);
        case (lsu_size_e'(op[1:0]))
            SIZE_HALF: err = err | addr[0];
            SIZE_WORD: err = err | (addr[1:0] != 2'b00);
            SIZE_ILL:  err = 1'b1;
            default:   err = err;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response channel from the MEM stage plus the
// word-addressed data-memory port of the load/store unit.
//   req_*   : one request per valid/ready handshake (op, byte addr, data)
//   resp_*  : one response per accepted request (rdata, err)
//   mem_*   : read strobe, write enable, word index, write/read data
// modport slave  - the load/store unit itself
// modport master - the environment (pipeline stage + data memory)
interface load_store_unit_if #(
    parameter int ADDR_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_merge.sv
// lsu_lane_merge: combinational lane handling for the load/store unit.
//   word_i     : memory word (captured read data)
//   lane_i     : byte address bits [1:0]
//   size_i     : access size (byte/half/word)
//   unsigned_i : zero-extend sub-word loads instead of sign-extending
//   sdata_i    : right-aligned store data
//   load_o     : extracted and extended load result
//   merge_o    : word_i with the addressed lane(s) replaced by sdata_i
//                (sdata_i itself for word accesses)
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [4:0]         byte_sh;
    logic [4:0]         half_sh;

    // Little-endian: byte lane n lives at bits 8n+7:8n, half lane at 16n.
    assign byte_sh = {lane_i, 3'b000};
    assign half_sh = {lane_i[1], 4'b0000};
    assign byte_s  = word_i[byte_sh +: 8];
    assign half_s  = word_i[half_sh +: 16];

    always_comb begin
        load_o  = word_i;
        merge_o = sdata_i;
        case (lsu_size_e'(size_i))
            SIZE_BYTE: begin
                load_o  = unsigned_i ? {24'd0, byte_s} : 32'(byte_s);
                merge_o = word_i;
                merge_o[byte_sh +: 8] = sdata_i[7:0];
            end
            SIZE_HALF: begin
                load_o  = unsigned_i ? {16'd0, half_s} : 32'(half_s);
                merge_o = word_i;
                merge_o[half_sh +: 16] = sdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = sdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the CPU data-memory port.
// Accepts one load/store at a time, drives the word-addressed memory and
// returns exactly one response per accepted request. Sub-word stores are
// done as read-modify-write because the memory only writes whole words.
// Ports:
//   clk   : system clock, all state updates on posedge
//   reset : synchronous, active-high; returns the unit to IDLE
//   bus   : load_store_unit_if.slave (request, response, memory port)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    bus
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;

    logic              req_err;
    logic              is_store;
    logic              is_word;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign req_err  = lsu_req_err(bus.req_op, bus.req_addr, ADDR_W);
    assign is_store = op_q[OP_STORE_BIT];
    assign is_word  = (lsu_size_e'(op_q[1:0]) == SIZE_WORD);

    lsu_lane_merge u_lane_merge (
        .word_i     (word_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (op_q[1:0]),
        .unsigned_i (op_q[OP_UNSIGNED_BIT]),
        .sdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        word_d         = word_q;
        err_d          = err_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.resp_err   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_wdata  = 32'd0;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr[ADDR_W+1:0];
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (bus.req_op[OP_STORE_BIT] &&
                                 lsu_size_e'(bus.req_op[1:0]) == SIZE_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = addr_q[ADDR_W+1:2];
                word_d       = bus.mem_rdata;
                state_d      = is_store ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = addr_q[ADDR_W+1:2];
                bus.mem_wdata = is_word ? wdata_q : merge_data;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                // Memory strobes are low here, so back-to-back reads always
                // see mem_read drop for at least one cycle.
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || is_store) ? 32'd0 : load_data;
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request and captured-word registers are only read in states that
    // are reached after they were loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        word_q  <= word_d;
        err_q   <= err_d;
    end

endmodule
